// File: rtl/seg_mux_driver_if.sv
// Display bus for seg_mux_driver: packed character codes in, digit enables and segments out.
interface seg_mux_driver_if;
  logic [19:0] big_bin;
  logic [3:0]  AN;
  logic [6:0]  seven_out;

  modport master (output big_bin, input AN, input seven_out);
  modport slave  (input big_bin, output AN, output seven_out);
endinterface

// File: rtl/seg_mux_driver.sv
// Multiplexed 4-digit common-anode seven-segment driver with a tick-enable refresh divider
// and a 5-bit character decoder; all outputs are registered and active-low.
module seg_mux_driver #(
  parameter int DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  seg_mux_driver_if.slave   bus
);

  localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  ONE  = CW'(1);

  function automatic logic clk_divider(input logic [CW-1:0] cnt);
    return (cnt == LAST);
  endfunction

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] binary_to_segment(input logic [4:0] code);
    logic [6:0] seg;
    case (code)
      5'd0:    seg = 7'b1000000;
      5'd1:    seg = 7'b1111001;
      5'd2:    seg = 7'b0100100;
      5'd3:    seg = 7'b0110000;
      5'd4:    seg = 7'b0011001;
      5'd5:    seg = 7'b0010010;
      5'd6:    seg = 7'b0000010;
      5'd7:    seg = 7'b1111000;
      5'd8:    seg = 7'b0000000;
      5'd9:    seg = 7'b0010000;
      5'd10:   seg = 7'b0001000;
      5'd11:   seg = 7'b0000011;
      5'd12:   seg = 7'b1000110;
      5'd13:   seg = 7'b0100001;
      5'd14:   seg = 7'b0000110;
      5'd15:   seg = 7'b0001110;
      5'd16:   seg = 7'b0001001;
      5'd17:   seg = 7'b1000111;
      5'd18:   seg = 7'b0001100;
      5'd19:   seg = 7'b1000001;
      5'd20:   seg = 7'b0101011;
      5'd21:   seg = 7'b0100011;
      5'd22:   seg = 7'b0101111;
      5'd23:   seg = 7'b0000111;
      5'd24:   seg = 7'b0010001;
      5'd25:   seg = 7'b0111111;
      5'd26:   seg = 7'b1110111;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  logic [CW-1:0] div_cnt_r;
  logic [1:0]    count_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          tick_s;
  logic [3:0]    an_next_s;
  logic [4:0]    code_s;

  assign tick_s = clk_divider(div_cnt_r);

  // Digit enable and character code for the digit currently selected by the scan counter
  always_comb begin
    an_next_s = 4'b1110;
    code_s    = bus.big_bin[4:0];
    case (count_r)
      2'd0: begin an_next_s = 4'b1110; code_s = bus.big_bin[4:0];   end
      2'd1: begin an_next_s = 4'b1101; code_s = bus.big_bin[9:5];   end
      2'd2: begin an_next_s = 4'b1011; code_s = bus.big_bin[14:10]; end
      2'd3: begin an_next_s = 4'b0111; code_s = bus.big_bin[19:15]; end
      default: begin an_next_s = 4'b1110; code_s = bus.big_bin[4:0]; end
    endcase
  end

  // Refresh divider: wraps to zero on the tick cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_r <= {CW{1'b0}};
    end else if (tick_s) begin
      div_cnt_r <= {CW{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + ONE;
    end
  end

  // Scan step: outputs load the digit for the pre-increment count, then hold until the next tick
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_r <= 2'd0;
      an_r    <= 4'b1110;
      seg_r   <= 7'b1111111;
    end else if (tick_s) begin
      count_r <= count_r + 2'd1;
      an_r    <= an_next_s;
      seg_r   <= binary_to_segment(code_s);
    end else begin
      count_r <= count_r;
      an_r    <= an_r;
      seg_r   <= seg_r;
    end
  end

  assign bus.AN        = an_r;
  assign bus.seven_out = seg_r;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Scoreboard bench: stimulus pushes per-edge expectations for a DIV=4 and a DIV=1 instance,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seg_mux_driver;

  typedef struct {
    int         ed;
    bit         ca;
    logic [3:0] an_a;
    logic [6:0] seg_a;
    bit         cb;
    logic [3:0] an_b;
    logic [6:0] seg_b;
  } exp_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_tests;
  int   n_fail;
  int   phase;
  exp_t q[$];
  logic [6:0] dec_tab [32];
  logic [3:0] an_tab [4];
  logic [6:0] seg_p2 [4];
  logic [6:0] seg_p3 [4];

  seg_mux_driver_if bus_a ();
  seg_mux_driver_if bus_b ();

  seg_mux_driver #(.DIV(4)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  seg_mux_driver #(.DIV(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int ed, input bit ca, input logic [3:0] ea, input logic [6:0] sa,
                     input bit cb, input logic [3:0] eb, input logic [6:0] sb);
    exp_t e;
    e.ed = ed; e.ca = ca; e.an_a = ea; e.seg_a = sa;
    e.cb = cb; e.an_b = eb; e.seg_b = sb;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per clock edge, compared on the following falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.ca) begin
          n_tests++;
          if (bus_a.AN !== e.an_a || bus_a.seven_out !== e.seg_a) begin
            n_fail++;
            $display("FAIL dut_a p%0d e%0d: got AN=%b seg=%b, expected AN=%b seg=%b",
                     phase, e.ed, bus_a.AN, bus_a.seven_out, e.an_a, e.seg_a);
          end
        end
        if (e.cb) begin
          n_tests++;
          if (bus_b.AN !== e.an_b || bus_b.seven_out !== e.seg_b) begin
            n_fail++;
            $display("FAIL dut_b p%0d e%0d: got AN=%b seg=%b, expected AN=%b seg=%b",
                     phase, e.ed, bus_b.AN, bus_b.seven_out, e.an_b, e.seg_b);
          end
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    phase   = 0;
    dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001; dec_tab[2]  = 7'b0100100;
    dec_tab[3]  = 7'b0110000; dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
    dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000; dec_tab[8]  = 7'b0000000;
    dec_tab[9]  = 7'b0010000; dec_tab[10] = 7'b0001000; dec_tab[11] = 7'b0000011;
    dec_tab[12] = 7'b1000110; dec_tab[13] = 7'b0100001; dec_tab[14] = 7'b0000110;
    dec_tab[15] = 7'b0001110; dec_tab[16] = 7'b0001001; dec_tab[17] = 7'b1000111;
    dec_tab[18] = 7'b0001100; dec_tab[19] = 7'b1000001; dec_tab[20] = 7'b0101011;
    dec_tab[21] = 7'b0100011; dec_tab[22] = 7'b0101111; dec_tab[23] = 7'b0000111;
    dec_tab[24] = 7'b0010001; dec_tab[25] = 7'b0111111; dec_tab[26] = 7'b1110111;
    for (int i = 27; i < 32; i++) dec_tab[i] = 7'b1111111;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    seg_p2[0] = 7'b1000000; seg_p2[1] = 7'b1111001; seg_p2[2] = 7'b0100100; seg_p2[3] = 7'b0110000;
    seg_p3[0] = 7'b1000000; seg_p3[1] = 7'b1111001; seg_p3[2] = 7'b0100100; seg_p3[3] = 7'b0111111;

    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.big_bin = 20'd0;
    bus_b.big_bin = 20'd0;

    // Phase 1: reset held for 3 edges on both instances
    phase = 1;
    for (int i = 1; i <= 3; i++) cyc(i, 1'b1, 4'b1110, BLANK, 1'b1, 4'b1110, BLANK);

    // Phase 2: DIV=4 scan of {3,2,1,0}, through one full repeat and into digit 2
    phase = 2;
    rst_a = 1'b1;
    bus_a.big_bin = {5'd3, 5'd2, 5'd1, 5'd0};
    for (int e = 1; e <= 29; e++) begin
      if (e < 4) cyc(e, 1'b1, 4'b1110, BLANK, 1'b1, 4'b1110, BLANK);
      else       cyc(e, 1'b1, an_tab[((e / 4) - 1) % 4], seg_p2[((e / 4) - 1) % 4],
                     1'b1, 4'b1110, BLANK);
    end

    // Mid-scan reset while digit 2 (AN=1011) is shown
    rst_a = 1'b0;
    cyc(30, 1'b1, 4'b1110, BLANK, 1'b1, 4'b1110, BLANK);

    // Phase 3: restart from digit 0; digit 3 code changes 0 -> 25 while digit 1 is shown
    phase = 3;
    rst_a = 1'b1;
    bus_a.big_bin = {5'd0, 5'd2, 5'd1, 5'd0};
    for (int e = 1; e <= 19; e++) begin
      if (e == 9) bus_a.big_bin[19:15] = 5'd25;
      if (e < 4) cyc(e, 1'b1, 4'b1110, BLANK, 1'b1, 4'b1110, BLANK);
      else       cyc(e, 1'b1, an_tab[((e / 4) - 1) % 4], seg_p3[((e / 4) - 1) % 4],
                     1'b1, 4'b1110, BLANK);
    end

    // Phase 4: DIV=1 rotates every edge; digit 0 sweeps all 32 codes, others blank code 31
    phase = 4;
    rst_b = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus_b.big_bin = {5'd31, 5'd31, 5'd31, 5'(c)};
      for (int k = 0; k < 4; k++)
        cyc(c * 4 + k, 1'b0, 4'b0000, BLANK, 1'b1, an_tab[k], (k == 0) ? dec_tab[c] : BLANK);
    end
    cyc(128, 1'b0, 4'b0000, BLANK, 1'b1, 4'b1110, dec_tab[31]);

    @(negedge clk);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
